// File: rtl/img_pkg.sv
// Shared pixel types and frame-engine state encoding for the grayscale path.
package img_pkg;
  localparam int PIX_W = 12;

  typedef logic [11:0] rgb444_t;
  typedef logic [3:0]  gray4_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} gfe_state_t;

  // Displayable gray: the same nibble on all three channels.
  function automatic rgb444_t gray_pix(input gray4_t g);
    return {g, g, g};
  endfunction
endpackage

// File: rtl/rgb2gray.sv
// Combinational RGB444 to 4-bit luma: (5R + 9G + 2B) >> 4.
module rgb2gray
  import img_pkg::*;
(
  input  rgb444_t rgb_in,
  output gray4_t  gray_out
);
  logic [7:0] sum;

  // Weights total 16, so the sum peaks at 240 and fits 8 bits.
  always_comb begin
    sum = {4'b0, rgb_in[11:8]} * 8'd5
        + {4'b0, rgb_in[7:4]}  * 8'd9
        + {4'b0, rgb_in[3:0]}  * 8'd2;
    gray_out = gray4_t'(sum >> 4);
  end
endmodule

// File: rtl/gray_frame_engine.sv
// Streams a frame through rgb2gray: read issued in cycle t is written back in t+2.
// Stall only holds new read issue; pixels already in the pipeline always complete.
module gray_frame_engine
  import img_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 96,
  parameter int AW    = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic          stall,
  output logic          busy,
  output logic          done,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [11:0]   rd_data,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [11:0]   wr_data
);
  localparam int NPIX = IMG_W * IMG_H;
  localparam logic [AW:0] NPIX_C = (AW+1)'(NPIX);
  localparam logic [AW:0] LAST_C = (AW+1)'(NPIX - 1);

  gfe_state_t    state;
  logic [AW-1:0] src_q, dst_q;
  logic [AW:0]   rd_cnt, wr_cnt;
  logic          s1_vld;
  gray4_t        gray;

  rgb2gray u_rgb2gray (
    .rgb_in   (rd_data),
    .gray_out (gray)
  );

  assign rd_en   = (state == RUN) && !stall;
  assign rd_addr = src_q + rd_cnt[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      s1_vld  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      // Fixed two-stage pipeline, independent of stall.
      s1_vld <= rd_en;
      wr_en  <= s1_vld;
      if (s1_vld) begin
        wr_data <= gray_pix(gray);
        wr_addr <= dst_q + wr_cnt[AW-1:0];
        wr_cnt  <= wr_cnt + 1'b1;
      end
      done <= 1'b0;

      case (state)
        IDLE: if (start) begin
          src_q  <= src_base;
          dst_q  <= dst_base;
          rd_cnt <= '0;
          wr_cnt <= '0;
          busy   <= 1'b1;
          state  <= RUN;
        end
        RUN: if (rd_en) begin
          rd_cnt <= rd_cnt + 1'b1;
          if (rd_cnt == LAST_C) state <= DRAIN;
        end
        // wr_cnt already counts the write on the bus this cycle.
        DRAIN: if (wr_en && wr_cnt == NPIX_C) begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
